sdrc_user_responder: RTL
========================

SDRC_USER_RESPONDER -- requirements
Module: sdrc_user_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
 - DATA_WIDTH, 16, user data width.
 - ADDR_WIDTH, 21, user address width.
 - LEN_WIDTH, 8, burst length field width.
 - MEM_AW, 10, backing store address bits (2^MEM_AW words).
 - INIT_CYCLES, 16, clocks from reset release to init done.
 - RD_LATENCY, 4, clocks from read command to first valid beat.
 - REF_PERIOD, 780, clocks between refresh requests.
 - REF_CYCLES, 8, clocks busy per refresh.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; one clock, reset asynchronous and active-high:
 - I_sdrc_clk, in, 1, sole clock.
 - I_sdrc_rst, in, 1, asynchronous active-high reset.
 - I_sdrc_wr_n, in, 1, write command strobe, active low.
 - I_sdrc_rd_n, in, 1, read command strobe, active low.
 - I_sdrc_addr, in, ADDR_WIDTH, burst start address.
 - I_sdrc_data_len, in, LEN_WIDTH, beats minus one.
 - I_sdrc_data, in, DATA_WIDTH, write data.
 - I_sdrc_dqm, in, DATA_WIDTH/8, per-byte write mask, 1 = masked.
 - I_sdrc_selfrefresh, in, 1, sleep request.
 - I_sdrc_power_down, in, 1, sleep request.
 - O_sdrc_init_done, out, 1, initialisation complete.
 - O_sdrc_busy_n, out, 1, high = command accepted this cycle.
 - O_sdrc_wrd_ack, out, 1, command acknowledge pulse.
 - O_sdrc_rd_valid, out, 1, read beat valid.
 - O_sdrc_data, out, DATA_WIDTH, read data.
 - O_sdrc_cmd_err, out, 1, dropped/illegal command pulse.

Function
REQ-003 SHALL implement states INIT, IDLE, WRITE, RD_WAIT, READ, REFRESH, SLEEP; all outputs registered.
REQ-004 INIT: SHALL count INIT_CYCLES clocks after reset release, then set O_sdrc_init_done=1 (sticky until reset) and enter IDLE.
REQ-005 O_sdrc_busy_n SHALL be 1 exactly in cycles where state is IDLE; 0 otherwise.
REQ-006 Command accepted at cycle T only if O_sdrc_busy_n=1 at T; wr_n=0 and rd_n=0 together SHALL be a write plus O_sdrc_cmd_err=1 at T+1.
REQ-007 Command asserted while busy_n=0 SHALL be ignored and pulse O_sdrc_cmd_err at the next cycle.
REQ-008 On acceptance SHALL latch addr and len, pulse O_sdrc_wrd_ack for one cycle at T+1.
REQ-009 Write: beat k (k=0..len) SHALL be sampled at T+1+k into mem[(addr[MEM_AW-1:0]+k) mod 2^MEM_AW], bytes with dqm=1 left unchanged; IDLE at T+2+len.
REQ-010 Read: O_sdrc_rd_valid=1 for exactly len+1 consecutive cycles starting T+RD_LATENCY, beat k = mem[(addr+k) mod 2^MEM_AW]; IDLE the cycle after the last beat.
REQ-011 O_sdrc_data SHALL hold its last value when rd_valid=0.
REQ-012 Refresh counter SHALL run from init done; on reaching REF_PERIOD-1 SHALL set refresh_pending and restart.
REQ-013 Pending refresh SHALL enter REFRESH from IDLE in the first cycle with no accepted command; busy for REF_CYCLES; pending cleared on entry.
REQ-014 A refresh request arising mid-burst SHALL not interrupt the burst; a second request while pending SHALL not be queued twice.
REQ-015 selfrefresh or power_down high in IDLE with no command and no pending refresh SHALL enter SLEEP; refresh counter frozen; IDLE the cycle after both are low.
REQ-016 len is an unsigned LEN_WIDTH value; len=0 is a single beat; address wrap within the backing store SHALL be silent.

Reset
REQ-017 I_sdrc_rst high SHALL asynchronously force INIT, init_done=0, busy_n=0, wrd_ack=0, rd_valid=0, cmd_err=0, data=0, all counters and refresh_pending=0.
REQ-018 Reset mid-burst SHALL abort the burst without further beats; memory contents are not cleared.

Verification
REQ-019 Release reset -> init_done=1 and busy_n=1 exactly 16 clocks later; command during INIT -> cmd_err pulse, no ack.
REQ-020 Write addr=5, len=10, data 0..10, dqm=0; then read addr=5, len=10 -> wrd_ack pulses; read data 0..10 on 11 consecutive rd_valid beats starting 4 clocks after the read command.
REQ-021 Write addr=0x3FE, len=3, data A0..A3; read addr=0x3FE, len=3 -> A0,A1,A2,A3 with words 2,3 stored at 0x000,0x001.
REQ-022 Write 0xFFFF to addr 8, then write 0x1234 with dqm=2'b10 -> read 0xFF34.
REQ-023 wr_n and rd_n low together, then a command during a burst -> write executes, cmd_err pulses twice, second command dropped.
REQ-024 Hold traffic across a refresh boundary, then assert reset mid-read -> busy_n low 8 clocks once, burst not split; after reset rd_valid=0 at once and INIT restarts.

Source files
------------

// File: rtl/sdrc_user_responder.sv
// sdrc_user_responder: behavioural SDRAM-controller user-side responder with a backing store, refresh and sleep.
module sdrc_user_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 21,
  parameter int LEN_WIDTH   = 8,
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 16,
  parameter int RD_LATENCY  = 4,
  parameter int REF_PERIOD  = 780,
  parameter int REF_CYCLES  = 8
) (
  input  logic                    I_sdrc_clk,
  input  logic                    I_sdrc_rst,
  input  logic                    I_sdrc_wr_n,
  input  logic                    I_sdrc_rd_n,
  input  logic [ADDR_WIDTH-1:0]   I_sdrc_addr,
  input  logic [LEN_WIDTH-1:0]    I_sdrc_data_len,
  input  logic [DATA_WIDTH-1:0]   I_sdrc_data,
  input  logic [DATA_WIDTH/8-1:0] I_sdrc_dqm,
  input  logic                    I_sdrc_selfrefresh,
  input  logic                    I_sdrc_power_down,
  output logic                    O_sdrc_init_done,
  output logic                    O_sdrc_busy_n,
  output logic                    O_sdrc_wrd_ack,
  output logic                    O_sdrc_rd_valid,
  output logic [DATA_WIDTH-1:0]   O_sdrc_data,
  output logic                    O_sdrc_cmd_err
);
  typedef enum logic [2:0] {INIT, IDLE, WRITE, RD_WAIT, READ, REFRESH, SLEEP} state_t;
  localparam int NB = DATA_WIDTH / 8;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d, beat_addr;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic pend_q, pend_d, init_done_q, init_done_d, busy_n_q, busy_n_d;
  logic ack_q, ack_d, rd_valid_q, rd_valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic cmd, acc, hit, last;
  logic unused_addr;
  assign unused_addr = ^I_sdrc_addr[ADDR_WIDTH-1:MEM_AW];
  always_comb begin
    cmd = !I_sdrc_wr_n || !I_sdrc_rd_n;
    acc = state_q == IDLE && cmd;
    hit = init_done_q && state_q != SLEEP && rcnt_q == 32'(REF_PERIOD - 1);
    last = cnt_q == 32'(len_q);
    beat_addr = addr_q + cnt_q[MEM_AW-1:0];
    state_d = state_q;
    cnt_d = cnt_q + 32'd1;
    addr_d = acc ? I_sdrc_addr[MEM_AW-1:0] : addr_q;
    len_d = acc ? I_sdrc_data_len : len_q;
    case (state_q)
      INIT:    state_d = cnt_q == 32'(INIT_CYCLES - 1) ? IDLE : INIT;
      IDLE:    state_d = acc ? (I_sdrc_wr_n ? RD_WAIT : WRITE) : pend_q ? REFRESH :
                         (I_sdrc_selfrefresh || I_sdrc_power_down) ? SLEEP : IDLE;
      WRITE:   state_d = last ? IDLE : WRITE;
      RD_WAIT: state_d = cnt_q == 32'(RD_LATENCY - 2) ? READ : RD_WAIT;
      READ:    state_d = last ? IDLE : READ;
      REFRESH: state_d = cnt_q == 32'(REF_CYCLES - 1) ? IDLE : REFRESH;
      SLEEP:   state_d = (I_sdrc_selfrefresh || I_sdrc_power_down) ? SLEEP : IDLE;
      default: state_d = INIT;
    endcase
    // one shared counter restarts at every state change: init, latency, beat and refresh timing
    if (state_d != state_q) cnt_d = '0;
    rcnt_d = (!init_done_q || state_q == SLEEP) ? rcnt_q : hit ? '0 : rcnt_q + 32'd1;
    pend_d = hit || (pend_q && !(state_q == IDLE && !acc));
    init_done_d = init_done_q || state_d == IDLE;
    busy_n_d = state_d == IDLE;
    ack_d = acc;
    err_d = cmd && (!acc || (!I_sdrc_wr_n && !I_sdrc_rd_n));
    rd_valid_d = state_d == READ;
    data_d = rd_valid_d ? mem[addr_d + cnt_d[MEM_AW-1:0]] : data_q;
  end
  always_ff @(posedge I_sdrc_clk or posedge I_sdrc_rst) begin
    if (I_sdrc_rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      rcnt_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      pend_q <= 1'b0;
      init_done_q <= 1'b0;
      busy_n_q <= 1'b0;
      ack_q <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcnt_q <= rcnt_d;
      addr_q <= addr_d;
      len_q <= len_d;
      pend_q <= pend_d;
      init_done_q <= init_done_d;
      busy_n_q <= busy_n_d;
      ack_q <= ack_d;
      rd_valid_q <= rd_valid_d;
      err_q <= err_d;
      data_q <= data_d;
    end
  end
  // backing store has no reset so contents survive an aborted burst
  always_ff @(posedge I_sdrc_clk) begin
    if (state_q == WRITE)
      for (int b = 0; b < NB; b++)
        if (!I_sdrc_dqm[b]) mem[beat_addr][8*b +: 8] <= I_sdrc_data[8*b +: 8];
  end
  assign O_sdrc_init_done = init_done_q;
  assign O_sdrc_busy_n = busy_n_q;
  assign O_sdrc_wrd_ack = ack_q;
  assign O_sdrc_rd_valid = rd_valid_q;
  assign O_sdrc_data = data_q;
  assign O_sdrc_cmd_err = err_q;
endmodule
